// File: rtl/man_pkg.sv
// Shared constants for the EM4100-style Manchester transmit path.
// Frame geometry and transmit sequencer state encodings.
package man_pkg;

   localparam int FRAME_LEN = 64;
   localparam int HDR_LEN   = 9;
   localparam int ID_LEN    = 40;
   localparam int ROWS      = 10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/em_frame_builder.sv
// Combinational EM4100 frame assembly from a 40-bit tag ID.
// Header ones, per-row even parity, column parity, stop bit.
module em_frame_builder
   import man_pkg::*;
(
   input  logic [ID_LEN-1:0]    in_id,
   output logic [FRAME_LEN-1:0] out_frame
);

   logic [3:0] w_nib;
   logic [3:0] w_col;

   // Lay out header, ten parity-protected rows, column parity, stop
   always_comb begin
      w_nib     = '0;
      w_col     = '0;
      out_frame = '0;
      out_frame[FRAME_LEN-1 -: HDR_LEN] = '1;
      for (int r = 0; r < ROWS; r++) begin
         w_nib = in_id[ID_LEN-1-4*r -: 4];
         out_frame[54-5*r -: 5] = {w_nib, ^w_nib};
         w_col = w_col ^ w_nib;
      end
      out_frame[4:1] = w_col;
      out_frame[0]   = 1'b0;
   end

endmodule

// File: rtl/man_tx_ctrl.sv
// Frame sequencer feeding the Manchester encoder.
// Latches an ID, builds the frame, shifts it out one bit per BIT_DIV clocks.
module man_tx_ctrl
   import man_pkg::*;
#(
   parameter int BIT_DIV = 64
)(
   input  logic        clk,
   input  logic        in_rst_n,
   input  logic        in_start,
   input  logic        in_abort,
   input  logic        in_repeat,
   input  logic [39:0] in_id,
   output logic        out_enc_clk,
   output logic        out_enc_enable,
   output logic        out_enc_data,
   output logic        out_busy,
   output logic        out_done,
   output logic [5:0]  out_bit_idx
);

   localparam int CW = $clog2(BIT_DIV);
   localparam logic [CW-1:0] CNT_MAX  = CW'(BIT_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(BIT_DIV / 2);

   logic [1:0]           r_state;
   logic [ID_LEN-1:0]    r_id;
   logic [FRAME_LEN-1:0] r_frame;
   logic [CW-1:0]        r_cnt;
   logic [5:0]           r_idx;

   logic [FRAME_LEN-1:0] w_frame;
   logic                 w_send;
   logic                 w_last;

   em_frame_builder u_builder (
      .in_id     (r_id),
      .out_frame (w_frame)
   );

   assign w_send = (r_state == ST_SEND);
   assign w_last = (r_cnt == CNT_MAX);

   // FSM, bit-period divider and bit index; abort beats repeat/completion
   always_ff @(posedge clk) begin
      if (!in_rst_n) begin
         r_state <= ST_IDLE;
         r_id    <= '0;
         r_frame <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else if (in_abort && (r_state != ST_IDLE)) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_start) begin
                  r_id    <= in_id;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_frame <= w_frame;
               r_cnt   <= '0;
               r_idx   <= 6'd63;
               r_state <= ST_SEND;
            end
            ST_SEND: begin
               if (w_last) begin
                  r_cnt <= '0;
                  if (r_idx == 6'd0) begin
                     if (in_repeat) r_idx <= 6'd63;
                     else           r_state <= ST_DONE;
                  end else begin
                     r_idx <= r_idx - 6'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Data follows the index, which only moves when cnt returns to 0,
   // so the encoder clock edge at cnt==1 always sees settled data.
   assign out_enc_enable = w_send;
   assign out_enc_data   = w_send & r_frame[r_idx];
   assign out_enc_clk    = w_send && (r_cnt != '0) && (r_cnt <= CNT_HALF);
   assign out_busy       = (r_state == ST_LOAD) || w_send;
   assign out_done       = (r_state == ST_DONE);
   assign out_bit_idx    = r_idx;

endmodule

// File: tb/tb_man_tx_ctrl.sv
// Scoreboard bench for man_tx_ctrl (BIT_DIV=8 main DUT, BIT_DIV=4 second DUT).
// Stimulus pushes expected frames/done times; negedge monitors pop and compare.
module tb_man_tx_ctrl;
   import man_pkg::*;

   localparam logic [63:0] F_ZERO = 64'hFF80_0000_0000_0000;
   localparam logic [63:0] F_ONES = 64'hFFFB_DEF7_BDEF_7BC0;
   localparam logic [63:0] F_SEQ  = 64'hFF8C_A64A_98F8_CA96;
   localparam logic [39:0] ID_SEQ = 40'h12_3456_789A;
   localparam logic [39:0] ID_ONE = 40'hFF_FFFF_FFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, abort, rpt;
   logic [39:0] id;
   logic        enc_clk, enc_en, enc_data, busy, done;
   logic [5:0]  bidx;

   logic        start2;
   logic [39:0] id2;
   logic        clk2, en2, data2, busy2, done2;
   logic [5:0]  bidx2;

   logic [39:0] bld_id;
   logic [63:0] bld_frame;

   man_tx_ctrl #(.BIT_DIV(8)) dut (
      .clk(clk), .in_rst_n(rst_n), .in_start(start), .in_abort(abort),
      .in_repeat(rpt), .in_id(id), .out_enc_clk(enc_clk),
      .out_enc_enable(enc_en), .out_enc_data(enc_data), .out_busy(busy),
      .out_done(done), .out_bit_idx(bidx)
   );

   man_tx_ctrl #(.BIT_DIV(4)) dut4 (
      .clk(clk), .in_rst_n(rst_n), .in_start(start2), .in_abort(1'b0),
      .in_repeat(1'b0), .in_id(id2), .out_enc_clk(clk2),
      .out_enc_enable(en2), .out_enc_data(data2), .out_busy(busy2),
      .out_done(done2), .out_bit_idx(bidx2)
   );

   em_frame_builder u_bld (.in_id(bld_id), .out_frame(bld_frame));

   typedef struct {
      int cyc;
      int en_len;
   } done_t;

   int errs = 0;
   int checks = 0;
   int cyc = 0;

   logic [63:0] q_frame[$];
   done_t       q_done[$];
   logic [63:0] q2_frame[$];
   int          q2_done[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bad(string name);
      checks++;
      errs++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitor for the BIT_DIV=8 DUT
   logic [63:0] cap;
   int          nbits = 0;
   int          en_len = 0;
   logic        p_clk = 1'b0;
   logic        p_en = 1'b0;
   done_t       d;

   always @(negedge clk) begin
      if (enc_en) en_len = p_en ? en_len + 1 : 1;
      if (!enc_en) nbits = 0;
      if (enc_clk && !p_clk) begin
         cap[bidx] = enc_data;
         nbits++;
         if (bidx == 6'd0) begin
            chk("frame_bits", nbits, 64);
            if (q_frame.size() == 0) bad("frame unexpected");
            else chk("frame", cap, q_frame.pop_front());
            nbits = 0;
         end
      end
      if (done) begin
         if (q_done.size() == 0) begin
            bad("done unexpected pulse");
         end else begin
            d = q_done.pop_front();
            chk("done_cycle", cyc, d.cyc);
            chk("enable_len", en_len, d.en_len);
            chk("done_outs", {busy, enc_en, enc_clk, enc_data, bidx}, '0);
         end
      end
      p_clk = enc_clk;
      p_en  = enc_en;
   end

   // Monitor for the BIT_DIV=4 DUT, including encoder clock timing
   logic [63:0] cap2;
   int          nbits2 = 0;
   int          upd2 = 0;
   int          last_rise2 = -1;
   logic        p_clk2 = 1'b0;
   logic        p_en2 = 1'b0;
   logic [5:0]  p_idx2 = '0;

   always @(negedge clk) begin
      if (en2 && (!p_en2 || bidx2 != p_idx2)) upd2 = cyc;
      if (!en2) begin
         last_rise2 = -1;
         nbits2 = 0;
      end
      if (clk2 && !p_clk2) begin
         chk("bd4_rise_lag", cyc - upd2, 1);
         if (last_rise2 >= 0) chk("bd4_clk_period", cyc - last_rise2, 4);
         last_rise2 = cyc;
         cap2[bidx2] = data2;
         nbits2++;
         if (bidx2 == 6'd0) begin
            chk("bd4_frame_bits", nbits2, 64);
            if (q2_frame.size() == 0) bad("bd4 frame unexpected");
            else chk("bd4_frame", cap2, q2_frame.pop_front());
            nbits2 = 0;
         end
      end
      if (done2) begin
         if (q2_done.size() == 0) bad("bd4 done unexpected pulse");
         else chk("bd4_done_cycle", cyc, q2_done.pop_front());
      end
      p_clk2 = clk2;
      p_en2  = en2;
      p_idx2 = bidx2;
   end

   task automatic tick(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic go(logic [39:0] v, logic [63:0] f, int nf);
      done_t e;
      id = v;
      start = 1'b1;
      for (int i = 0; i < nf; i++) q_frame.push_back(f);
      e.cyc = cyc + 2 + nf * 512;
      e.en_len = nf * 512;
      q_done.push_back(e);
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic wait_idle(int limit);
      for (int i = 0; i < limit; i++) begin
         if (q_done.size() == 0 && q2_done.size() == 0) return;
         tick();
      end
      bad("timeout waiting for done");
      q_done.delete();
      q_frame.delete();
      q2_done.delete();
      q2_frame.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b1;
      abort = 1'b0;
      rpt = 1'b0;
      id = ID_SEQ;
      start2 = 1'b1;
      id2 = ID_SEQ;
      bld_id = '0;

      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_outs", {enc_clk, enc_en, enc_data, busy, done, bidx}, '0);
         chk("reset_outs4", {clk2, en2, data2, busy2, done2, bidx2}, '0);
      end
      start = 1'b0;
      start2 = 1'b0;
      rst_n = 1'b1;
      tick(3);
      chk("no_start_after_reset", {busy, busy2}, '0);

      bld_id = '0;
      #1 chk("builder_zero", bld_frame, F_ZERO);
      bld_id = ID_ONE;
      #1 chk("builder_ones", bld_frame, F_ONES);
      bld_id = ID_SEQ;
      #1 chk("builder_seq", bld_frame, F_SEQ);
      tick();

      go(40'h0, F_ZERO, 1);
      wait_idle(700);
      tick(3);

      go(ID_ONE, F_ONES, 1);
      wait_idle(700);
      tick(3);

      rpt = 1'b1;
      go(ID_SEQ, F_SEQ, 3);
      tick(1100);
      rpt = 1'b0;
      wait_idle(1000);
      tick(3);

      id = ID_SEQ;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (enc_en && bidx == 6'd30) break;
         tick();
      end
      if (!(enc_en && bidx == 6'd30)) bad("abort point idx 30 never reached");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_outs", {enc_clk, enc_en, enc_data, busy, done, bidx}, '0);
      go(ID_ONE, F_ONES, 1);
      wait_idle(700);
      tick(3);

      go(ID_ONE, F_ONES, 1);
      tick(100);
      id = ID_SEQ;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(700);
      tick(20);
      chk("ignored_start_idle", busy, 0);

      id2 = ID_SEQ;
      start2 = 1'b1;
      q2_frame.push_back(F_SEQ);
      q2_done.push_back(cyc + 2 + 256);
      tick();
      start2 = 1'b0;
      wait_idle(400);
      tick(5);
      chk("bd4_idle_after", busy2, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
